regfile_mp: RTL

//  Parametrised multi-port register file for the five-stage MIPS pipeline with per-byte write strobes,

---
 rtl/regfile_mp.sv | 95 +++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with byte strobes, optional write-to-read bypass
// and a per-register pending-write scoreboard.
module regfile_mp #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NW*DW/8-1:0] we,
  input  logic [NW*AW-1:0]   wa,
  input  logic [NW*DW-1:0]   wd,
  input  logic [NR*AW-1:0]   ra,
  output logic [NR*DW-1:0]   rd,
  output logic [NR-1:0]      rbusy,
  input  logic               sb_set,
  input  logic [AW-1:0]      sb_addr
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    rf [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] clr;
  logic [DEPTH-1:0] set;

  always_comb begin
    clr = '0;
    set = '0;
    for (int i = 0; i < NW; i++) begin
      if (|we[i*NB +: NB]) clr[wa[i*AW +: AW]] = 1'b1;
    end
    if (sb_set) set[sb_addr] = 1'b1;
    clr[0] = 1'b0;
    set[0] = 1'b0;
  end

  // set is OR-ed in after the clear so a new producer wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr) | set;
    end
  end

  // ascending port loop: the last assignment (highest port) wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int a = 0; a < DEPTH; a++) rf[a] <= '0;
    end else begin
      for (int i = 0; i < NW; i++) begin
        for (int k = 0; k < NB; k++) begin
          if (we[i*NB+k] && (wa[i*AW +: AW] != '0)) begin
            rf[wa[i*AW +: AW]][k*8 +: 8] <= wd[i*DW+k*8 +: 8];
          end
        end
      end
    end
  end

  always_comb begin : rd_blk
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    logic          bsy;
    rd    = '0;
    rbusy = '0;
    addr  = '0;
    val   = '0;
    bsy   = 1'b0;
    for (int j = 0; j < NR; j++) begin
      addr = ra[j*AW +: AW];
      val  = rf[addr];
      bsy  = busy[addr];
      if (BYPASS != 0) begin
        for (int i = 0; i < NW; i++) begin
          for (int k = 0; k < NB; k++) begin
            if (we[i*NB+k] && (wa[i*AW +: AW] == addr)) begin
              val[k*8 +: 8] = wd[i*DW+k*8 +: 8];
            end
          end
        end
        if (clr[addr] && !set[addr]) bsy = 1'b0;
      end
      if (resetn && (addr != '0)) begin
        rd[j*DW +: DW] = val;
        rbusy[j]       = bsy;
      end
    end
  end

endmodule
